// File: rtl/seq_restoring_divider_pkg.sv
// seq_restoring_divider_pkg: shared FSM encoding and counter sizing for the restoring divider
package seq_restoring_divider_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
    // Iteration counter must hold the value WIDTH itself.
    function automatic int div_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction
endpackage

// File: rtl/div_sub_stage.sv
// div_sub_stage: trial subtractor a + ~b + 1 with sign flag
// Ports: a, b minuend/subtrahend (WIDTH bits); diff a-b; neg = diff MSB.
module div_sub_stage #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             neg
);
    assign diff = a + ~b + 1'b1;
    assign neg  = diff[WIDTH-1];
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle unsigned restoring divider, one quotient bit per clock
// Ports: clk, rst (sync, active-high); start/dividend/divisor request sampled in IDLE;
// busy high in RUN; done one-cycle pulse with quotient/remainder/div_by_zero, held until next completion.
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = div_cnt_w(WIDTH);

    state_t           state;
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [CNT_W-1:0] count;
    logic             dz;
    logic [WIDTH:0]   a_sh;
    logic [WIDTH:0]   diff;
    logic             neg;

    // A stays below M after every step, so its MSB is always free for the shift.
    assign a_sh = {a[WIDTH-1:0], q[WIDTH-1]};

    div_sub_stage #(.WIDTH(WIDTH + 1)) u_sub (
        .a    (a_sh),
        .b    ({1'b0, m}),
        .diff (diff),
        .neg  (neg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            a           <= '0;
            q           <= '0;
            m           <= '0;
            count       <= '0;
            dz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    if (divisor != '0) begin
                        a     <= '0;
                        q     <= dividend;
                        m     <= divisor;
                        count <= CNT_W'(WIDTH);
                        dz    <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        // Preload the zero-divisor result so DONE publishes it unchanged.
                        a     <= {1'b0, dividend};
                        q     <= '1;
                        m     <= '0;
                        count <= '0;
                        dz    <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_RUN: begin
                    a     <= neg ? a_sh : diff;
                    q     <= {q[WIDTH-2:0], ~neg};
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    quotient    <= q;
                    remainder   <= a[WIDTH-1:0];
                    div_by_zero <= dz;
                    done        <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed table, corner sequences and exhaustive sweep for the divider
module tb_seq_restoring_divider;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Issue one request in the current cycle and wait for its done pulse.
    task automatic do_op(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        int lat;
        int bad_busy;
        int exp_lat;
        exp_lat  = (y != 0) ? W + 1 : 1;
        start    = 1'b1;
        dividend = x;
        divisor  = y;
        tick();
        start    = 1'b0;
        lat      = 0;
        bad_busy = 0;
        while (!done && lat < 30) begin
            if (busy !== ((y != 0) && lat < W)) bad_busy++;
            tick();
            lat++;
        end
        check({nm, " latency"}, lat, exp_lat);
        check({nm, " busy"}, bad_busy, 0);
        check({nm, " quotient"}, quotient, eq);
        check({nm, " remainder"}, remainder, er);
        check({nm, " div_by_zero"}, div_by_zero, edz);
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done) cnt++;
        end
    endtask

    initial begin
        vec_t vecs[8];
        int   lat;
        int   cnt;
        vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0};
        vecs[1] = '{4'd9,  4'd2,  4'd4,  4'd1, 1'b0};
        vecs[2] = '{4'd2,  4'd9,  4'd0,  4'd2, 1'b0};
        vecs[3] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0};
        vecs[4] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0};
        vecs[5] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0};
        vecs[6] = '{4'd7,  4'd0,  4'd15, 4'd7, 1'b1};
        vecs[7] = '{4'd6,  4'd3,  4'd2,  4'd0, 1'b0};

        tick();
        tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset div_by_zero", div_by_zero, 0);
        rst = 1'b0;
        tick();

        // Back-to-back: each new start is driven in the done cycle.
        for (int i = 0; i < 8; i++)
            do_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].eq, vecs[i].er, vecs[i].edz);
        tick();
        check("single done pulse", done, 0);

        // A start pulse during RUN must be ignored.
        start = 1'b1; dividend = 4'd12; divisor = 4'd5;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; dividend = 4'd1; divisor = 4'd1;
        tick();
        start = 1'b0;
        lat = 2;
        while (!done && lat < 30) begin
            tick();
            lat++;
        end
        check("ignored start latency", lat, W + 1);
        check("ignored start quotient", quotient, 2);
        check("ignored start remainder", remainder, 2);
        count_dones(12, cnt);
        check("ignored start no second done", cnt, 0);

        // Reset mid-operation aborts silently; start during reset is dropped.
        start = 1'b1; dividend = 4'd14; divisor = 4'd4;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort quotient", quotient, 0);
        check("abort remainder", remainder, 0);
        check("abort div_by_zero", div_by_zero, 0);
        tick();
        check("start with rst ignored", busy, 0);
        count_dones(12, cnt);
        check("abort no done", cnt, 0);
        do_op("after abort", 4'd14, 4'd4, 4'd3, 4'd2, 1'b0);

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                do_op($sformatf("sweep %0d/%0d", i, j), W'(i), W'(j),
                      (j != 0) ? W'(i / j) : '1, (j != 0) ? W'(i % j) : W'(i), j == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
